// File: rtl/dual_core_mem_arbiter_pkg.sv
// Shared constants and types for the dual-core BRAM arbiter.
package arbiter_pkg;

  localparam int CORE0 = 0;
  localparam int CORE1 = 1;

  localparam int DEF_NUM_CORES        = 2;
  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_ADDRESS_BITS     = 32;
  localparam int DEF_MEM_ADDRESS_BITS = 14;
  localparam int STALL_WIDTH          = 32;

  localparam logic [STALL_WIDTH-1:0] STALL_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    GRANT_CORE0 = 1'b0,
    GRANT_CORE1 = 1'b1
  } core_id_e;

  function automatic logic [STALL_WIDTH-1:0] sat_inc(input logic [STALL_WIDTH-1:0] v);
    return (v == STALL_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// Core request/response bus plus BRAM port, shared by the arbiter and its environment.
interface dual_core_mem_arbiter_if #(
  parameter int NUM_CORES        = arbiter_pkg::DEF_NUM_CORES,
  parameter int DATA_WIDTH       = arbiter_pkg::DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS     = arbiter_pkg::DEF_ADDRESS_BITS,
  parameter int MEM_ADDRESS_BITS = arbiter_pkg::DEF_MEM_ADDRESS_BITS
);
  logic [NUM_CORES-1:0]                          req_valid;
  logic [NUM_CORES-1:0]                          req_write;
  logic [NUM_CORES*ADDRESS_BITS-1:0]             req_address;
  logic [NUM_CORES*DATA_WIDTH-1:0]               req_data;
  logic [NUM_CORES-1:0]                          req_ready;
  logic [NUM_CORES-1:0]                          rsp_valid;
  logic [NUM_CORES*DATA_WIDTH-1:0]               rsp_data;
  logic [NUM_CORES*arbiter_pkg::STALL_WIDTH-1:0] stall_count;
  logic                                          mem_en;
  logic                                          mem_we;
  logic [MEM_ADDRESS_BITS-1:0]                   mem_address;
  logic [DATA_WIDTH-1:0]                         mem_wdata;
  logic [DATA_WIDTH-1:0]                         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_address, req_data, mem_rdata,
    output req_ready, rsp_valid, rsp_data, stall_count,
           mem_en, mem_we, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_address, req_data, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, stall_count,
           mem_en, mem_we, mem_address, mem_wdata
  );
endinterface

// File: rtl/dual_core_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant only moves on an actual grant.
module rr_arbiter2
  import arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);
  core_id_e last_grant_q, last_grant_d;

  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    if (!reset) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_grant_q == GRANT_CORE1) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    if (grant_o[CORE1])      last_grant_d = GRANT_CORE1;
    else if (grant_o[CORE0]) last_grant_d = GRANT_CORE0;
  end

  // Reset to core 1 so that core 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) last_grant_q <= GRANT_CORE1;
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Shares one single-port BRAM between two cores: one access per cycle, response one cycle later.
module dual_core_mem_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_CORES        = DEF_NUM_CORES,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS     = DEF_ADDRESS_BITS,
  parameter int MEM_ADDRESS_BITS = DEF_MEM_ADDRESS_BITS
) (
  input logic clock,
  input logic reset,
  dual_core_mem_arbiter_if.slave bus
);
  logic [1:0]              grant;
  logic                    win_idx;
  logic [ADDRESS_BITS-1:0] win_addr;
  logic                    rsp_pending_q, rsp_pending_d;
  logic                    rsp_core_q, rsp_core_d;
  logic                    rsp_is_write_q, rsp_is_write_d;
  logic                    unused_addr_bits;

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .valid_i(bus.req_valid[1:0]),
    .grant_o(grant)
  );

  assign bus.req_ready = grant;
  assign win_idx       = grant[CORE1];
  assign win_addr      = win_idx ? bus.req_address[ADDRESS_BITS +: ADDRESS_BITS]
                                 : bus.req_address[0 +: ADDRESS_BITS];
  // Byte offset and bits above the BRAM range are dropped, so addresses wrap.
  assign unused_addr_bits = ^{win_addr[ADDRESS_BITS-1:MEM_ADDRESS_BITS+2], win_addr[1:0]};

  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    if (|grant) begin
      bus.mem_en      = 1'b1;
      bus.mem_we      = bus.req_write[win_idx];
      bus.mem_address = win_addr[MEM_ADDRESS_BITS+1:2];
      bus.mem_wdata   = win_idx ? bus.req_data[DATA_WIDTH +: DATA_WIDTH]
                                : bus.req_data[0 +: DATA_WIDTH];
    end
  end

  always_comb begin
    rsp_pending_d  = |grant;
    rsp_core_d     = rsp_core_q;
    rsp_is_write_d = rsp_is_write_q;
    if (|grant) begin
      rsp_core_d     = win_idx;
      rsp_is_write_d = bus.req_write[win_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_pending_q  <= 1'b0;
      rsp_core_q     <= 1'b0;
      rsp_is_write_q <= 1'b0;
    end else begin
      rsp_pending_q  <= rsp_pending_d;
      rsp_core_q     <= rsp_core_d;
      rsp_is_write_q <= rsp_is_write_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   slot_hit;

    assign slot_hit = rsp_pending_q && (rsp_core_q == 1'(gi));
    assign bus.rsp_valid[gi] = slot_hit;
    // Write acks carry zero data; only reads forward the BRAM output.
    assign bus.rsp_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (slot_hit && !rsp_is_write_q) ? bus.mem_rdata : '0;

    always_comb begin
      stall_d = stall_q;
      if (bus.req_valid[gi] && !grant[gi]) stall_d = sat_inc(stall_q);
    end

    always_ff @(posedge clock) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
    end

    assign bus.stall_count[gi*STALL_WIDTH +: STALL_WIDTH] = stall_q;
  end
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Randomised and directed checks of the arbiter against a transaction-level model.
module tb_dual_core_mem_arbiter;
  localparam int WORDS = 1 << 14;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dual_core_mem_arbiter_if bus ();
  dual_core_mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  function automatic logic [31:0] init_word(input int i);
    return (i == 7) ? 32'd3 : (32'(i) * 32'h9E37_79B1) + 32'h0000_1234;
  endfunction

  // Write-first BRAM with registered read; unwritten words hold init_word.
  logic [31:0] bram [WORDS];
  bit          bram_wr [WORDS];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        bram[bus.mem_address]    <= bus.mem_wdata;
        bram_wr[bus.mem_address] <= 1'b1;
        bus.mem_rdata            <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= bram_wr[bus.mem_address] ? bram[bus.mem_address]
                                                  : init_word(int'(bus.mem_address));
      end
    end
  end

  int errors = 0;
  int checks = 0;

  // Transaction-level model state.
  logic [31:0] m_mem [WORDS];
  int          m_last;
  bit          m_pend;
  int          m_rcore;
  logic [31:0] m_rdata;
  logic [31:0] m_stall [2];
  bit          have_eval = 0;

  int          e_win;
  logic [1:0]  e_ready, e_rvalid;
  logic        e_en, e_we;
  logic [13:0] e_addr;
  logic [31:0] e_wdata, e_hs_data;
  logic [63:0] e_rdata;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(WORDS));
  endfunction

  task automatic model_eval();
    logic [31:0] a;
    e_win = -1;
    if (!reset) begin
      if (bus.req_valid == 2'b01)      e_win = 0;
      else if (bus.req_valid == 2'b10) e_win = 1;
      else if (bus.req_valid == 2'b11) e_win = 1 - m_last;
    end
    e_ready = 2'b00; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_hs_data = '0;
    if (e_win >= 0) begin
      a = bus.req_address[e_win*32 +: 32];
      e_ready[e_win] = 1'b1;
      e_en      = 1'b1;
      e_we      = bus.req_write[e_win];
      e_addr    = 14'(word_of(a));
      e_wdata   = bus.req_data[e_win*32 +: 32];
      e_hs_data = e_we ? 32'd0 : m_mem[word_of(a)];
    end
    e_rvalid = 2'b00;
    e_rdata  = '0;
    if (m_pend) begin
      e_rvalid[m_rcore] = 1'b1;
      e_rdata[m_rcore*32 +: 32] = m_rdata;
    end
  endtask

  task automatic model_commit();
    if (reset) begin
      m_last = 1; m_pend = 0; m_stall[0] = '0; m_stall[1] = '0;
      return;
    end
    for (int i = 0; i < 2; i++)
      if (bus.req_valid[i] && e_win != i && m_stall[i] != 32'hFFFF_FFFF)
        m_stall[i] = m_stall[i] + 1;
    if (e_win >= 0) begin
      m_pend = 1; m_rcore = e_win; m_rdata = e_hs_data; m_last = e_win;
      if (e_we) m_mem[e_addr] = e_wdata;
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic apply(input logic rst, input logic [1:0] v, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clock);
    if (have_eval) model_commit();
    reset           = rst;
    bus.req_valid   = v;
    bus.req_write   = w;
    bus.req_address = {a1, a0};
    bus.req_data    = {d1, d0};
    #1;
    model_eval();
    have_eval = 1;
  endtask

  task automatic idle(input logic rst);
    apply(rst, 2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(1'b1, 2'b11, 2'b11, 32'h10, 32'h20, 32'h5, 32'h6);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    checks++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we: got %b want 00", {bus.mem_en, bus.mem_we}); end
    checks++; if ({bus.mem_address, bus.mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_addr_data: got %h/%h want 0/0", bus.mem_address, bus.mem_wdata); end
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp: got %b/%h want 00/0", bus.rsp_valid, bus.rsp_data); end
    checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL reset_stall: got %h want 0", bus.stall_count); end
  endtask

  task automatic test_single_read();
    apply(1'b0, 2'b01, 2'b00, 32'h1C, 0, 0, 0);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
    checks++; if (bus.mem_address !== 14'd7 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL single_mem: got a=%0d en=%b we=%b want a=7 en=1 we=0", bus.mem_address, bus.mem_en, bus.mem_we); end
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data[31:0] !== 32'd3) begin errors++; $display("FAIL single_rsp: got %b/%h want 01/3", bus.rsp_valid, bus.rsp_data[31:0]); end
    checks++; if (bus.stall_count[31:0] !== 32'd0) begin errors++; $display("FAIL single_stall0: got %0d want 0", bus.stall_count[31:0]); end
  endtask

  task automatic test_contention();
    idle(1'b1);
    apply(1'b0, 2'b11, 2'b00, 32'h20, 32'hB0, 0, 0);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL contend_first: got %b want 01", bus.req_ready); end
    apply(1'b0, 2'b10, 2'b00, 32'h20, 32'hB0, 0, 0);
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL contend_second: got %b want 10", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== e_rdata) begin errors++; $display("FAIL contend_rsp0: got %b/%h want 01/%h", bus.rsp_valid, bus.rsp_data, e_rdata); end
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== e_rdata) begin errors++; $display("FAIL contend_rsp1: got %b/%h want 10/%h", bus.rsp_valid, bus.rsp_data, e_rdata); end
    checks++; if (bus.stall_count !== {32'd1, 32'd0}) begin errors++; $display("FAIL contend_stall: got %h want 00000001_00000000", bus.stall_count); end
  endtask

  task automatic test_alternate();
    idle(1'b1);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 2'b11, 2'b00, $urandom, $urandom, 0, 0);
      checks++;
      if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || bus.req_ready !== e_ready) begin
        errors++; $display("FAIL alternate_grant[%0d]: got %b want %b", k, bus.req_ready, e_ready);
      end
    end
    idle(1'b0);
    checks++; if (bus.stall_count !== {32'd3, 32'd3}) begin errors++; $display("FAIL alternate_stall: got %h want 00000003_00000003", bus.stall_count); end
  endtask

  task automatic test_write_read();
    apply(1'b0, 2'b10, 2'b10, 0, 32'h30, 0, 32'h123);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h123 || bus.mem_address !== 14'd12) begin errors++; $display("FAIL wr_mem: got we=%b d=%h a=%0d want we=1 d=123 a=12", bus.mem_we, bus.mem_wdata, bus.mem_address); end
    apply(1'b0, 2'b10, 2'b00, 0, 32'h30, 0, 0);
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data[63:32] !== 32'd0) begin errors++; $display("FAIL wr_ack: got %b/%h want 10/0", bus.rsp_valid, bus.rsp_data[63:32]); end
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data[63:32] !== 32'h123) begin errors++; $display("FAIL raw_data: got %b/%h want 10/123", bus.rsp_valid, bus.rsp_data[63:32]); end
  endtask

  task automatic test_wrap();
    apply(1'b0, 2'b01, 2'b00, 32'h0001_001C, 0, 0, 0);
    checks++; if (bus.mem_address !== 14'd7) begin errors++; $display("FAIL wrap_addr: got %0d want 7", bus.mem_address); end
    idle(1'b0);
    checks++; if (bus.rsp_data[31:0] !== 32'd3) begin errors++; $display("FAIL wrap_data: got %h want 3", bus.rsp_data[31:0]); end
  endtask

  task automatic test_reset_midop();
    apply(1'b0, 2'b01, 2'b00, 32'h1C, 0, 0, 0);
    idle(1'b1);
    idle(1'b0);
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== '0) begin errors++; $display("FAIL midreset_rsp: got %b/%h want 00/0", bus.rsp_valid, bus.rsp_data); end
    checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL midreset_stall: got %h want 0", bus.stall_count); end
    apply(1'b0, 2'b11, 2'b00, 32'h40, 32'h44, 0, 0);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midreset_first_grant: got %b want 01", bus.req_ready); end
    idle(1'b0);
  endtask

  task automatic test_saturation();
    idle(1'b0);
    force dut.g_core[0].stall_q = 32'hFFFF_FFFE;
    m_stall[0] = 32'hFFFF_FFFE;
    idle(1'b0);
    checks++; if (bus.stall_count[31:0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h want fffffffe", bus.stall_count[31:0]); end
    release dut.g_core[0].stall_q;
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 2'b11, 2'b00, $urandom, $urandom, 0, 0);
      checks++; if (bus.stall_count[31:0] !== m_stall[0]) begin errors++; $display("FAIL sat_step[%0d]: got %h want %h", k, bus.stall_count[31:0], m_stall[0]); end
    end
    idle(1'b0);
    checks++; if (bus.stall_count[31:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", bus.stall_count[31:0]); end
  endtask

  task automatic test_random();
    logic [31:0] a0, a1;
    idle(1'b1);
    for (int n = 0; n < 400; n++) begin
      a0 = (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'hFFFF_0003);
      a1 = (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'hFFFF_0003);
      apply(1'b0, 2'($urandom), 2'($urandom), a0, a1, $urandom, $urandom);
      checks++;
      if (bus.req_ready !== e_ready || bus.mem_en !== e_en || bus.mem_we !== e_we ||
          bus.mem_address !== e_addr || bus.mem_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got rdy=%b en=%b we=%b a=%0d d=%h want rdy=%b en=%b we=%b a=%0d d=%h",
                 n, bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_address, bus.mem_wdata,
                 e_ready, e_en, e_we, e_addr, e_wdata);
      end
      checks++;
      if (bus.rsp_valid !== e_rvalid || bus.rsp_data !== e_rdata) begin
        errors++; $display("FAIL rand_rsp[%0d]: got %b/%h want %b/%h", n, bus.rsp_valid, bus.rsp_data, e_rvalid, e_rdata);
      end
      checks++;
      if (bus.stall_count !== {m_stall[1], m_stall[0]}) begin
        errors++; $display("FAIL rand_stall[%0d]: got %h want %h", n, bus.stall_count, {m_stall[1], m_stall[0]});
      end
    end
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_address = '0;
    bus.req_data    = '0;
    for (int i = 0; i < WORDS; i++) m_mem[i] = init_word(i);
    m_last = 1; m_pend = 0; m_rcore = 0; m_rdata = '0;
    m_stall[0] = '0; m_stall[1] = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_alternate();
    test_write_read();
    test_wrap();
    test_reset_midop();
    test_saturation();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
